// File: rtl/edge_event_detector.sv
// edge_event_detector
//   Per-channel edge detector for signals that may be asynchronous to ACLK.
//   Each channel is synchronised, compared against its previous value and
//   qualified by a per-channel mode. A qualified edge (det) does three things:
//   it starts or extends a stretched pulse, it sets a sticky flag and it
//   increments a saturating counter.
//
// Ports
//   ACLK        sole clock, rising edge
//   ARESETN     synchronous active-low reset
//   sig_in      [NUM_CH]        monitored signals
//   mode        [2*NUM_CH]      per channel: 00 off, 01 rise, 10 fall, 11 both
//   clr_flag    [NUM_CH]        sticky-flag clear strobe
//   clr_cnt     [NUM_CH]        counter clear strobe
//   edge_pulse  [NUM_CH]        stretched event pulse, PULSE_LEN cycles
//   edge_flag   [NUM_CH]        sticky event flag
//   edge_cnt    [NUM_CH*CNT_W]  saturating event count, channel i at [CNT_W*i +: CNT_W]
//   any_flag                    OR of all edge_flag bits
module edge_event_detector #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int CNT_W       = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_CH-1:0]         sig_in,
  input  logic [2*NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]         clr_flag,
  input  logic [NUM_CH-1:0]         clr_cnt,
  output logic [NUM_CH-1:0]         edge_pulse,
  output logic [NUM_CH-1:0]         edge_flag,
  output logic [NUM_CH*CNT_W-1:0]   edge_cnt,
  output logic                      any_flag
);

  localparam int               ARM_W      = 3;
  localparam logic [ARM_W-1:0] ARM_INIT   = ARM_W'(SYNC_STAGES + 1);
  localparam logic [3:0]       PULSE_INIT = 4'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [NUM_CH-1:0]        w_sync;
  logic [NUM_CH-1:0]        r_prev;
  logic [NUM_CH-1:0]        w_rise;
  logic [NUM_CH-1:0]        w_fall;
  logic [NUM_CH-1:0]        w_det;
  logic [NUM_CH-1:0]        w_flag_nxt;
  logic [NUM_CH-1:0]        w_pulse_nxt;
  logic [NUM_CH-1:0]        r_pulse;
  logic [NUM_CH-1:0]        r_flag;
  logic                     r_any;
  logic [NUM_CH*4-1:0]      r_stretch;
  logic [NUM_CH*4-1:0]      w_stretch_nxt;
  logic [NUM_CH*CNT_W-1:0]  r_cnt;
  logic [NUM_CH*CNT_W-1:0]  w_cnt_nxt;
  logic [ARM_W-1:0]         r_arm_cnt;
  logic                     w_armed;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = sig_in;
    end else begin : g_sync
      logic [NUM_CH-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
          for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
          r_sync[0] <= sig_in;
          for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end

      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // After reset the synchronisers fill with whatever level sig_in holds while
  // prev is still 0; masking det until the pipeline has settled keeps a level
  // that was already high at release from looking like a rising edge.
  always_ff @(posedge ACLK) begin
    if (!ARESETN)               r_arm_cnt <= ARM_INIT;
    else if (r_arm_cnt != '0)   r_arm_cnt <= r_arm_cnt - ARM_W'(1);
  end

  assign w_armed = (r_arm_cnt == '0);

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [3:0]       w_st;
      logic [CNT_W-1:0] w_cn;

      assign w_st = r_stretch[4*i +: 4];
      assign w_cn = r_cnt[CNT_W*i +: CNT_W];

      assign w_rise[i] = w_sync[i] & ~r_prev[i];
      assign w_fall[i] = ~w_sync[i] & r_prev[i];
      assign w_det[i]  = w_armed & ((mode[2*i] & w_rise[i]) | (mode[2*i+1] & w_fall[i]));

      // det reloads the down-counter even mid-pulse, so back-to-back events
      // extend the pulse without a gap.
      assign w_stretch_nxt[4*i +: 4] = w_det[i]       ? PULSE_INIT :
                                       (w_st != 4'd0) ? w_st - 4'd1 : 4'd0;
      assign w_pulse_nxt[i] = (w_stretch_nxt[4*i +: 4] != 4'd0);

      // A coincident det wins over the clear so no event is lost.
      assign w_flag_nxt[i] = w_det[i] | (r_flag[i] & ~clr_flag[i]);

      assign w_cnt_nxt[CNT_W*i +: CNT_W] =
        clr_cnt[i]                       ? (w_det[i] ? CNT_ONE : '0) :
        (w_det[i] && (w_cn != CNT_MAX))  ? w_cn + CNT_ONE            : w_cn;
    end
  endgenerate

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_prev    <= '0;
      r_stretch <= '0;
      r_pulse   <= '0;
      r_flag    <= '0;
      r_cnt     <= '0;
      r_any     <= 1'b0;
    end else begin
      r_prev    <= w_sync;
      r_stretch <= w_stretch_nxt;
      r_pulse   <= w_pulse_nxt;
      r_flag    <= w_flag_nxt;
      r_cnt     <= w_cnt_nxt;
      r_any     <= |w_flag_nxt;
    end
  end

  assign edge_pulse = r_pulse;
  assign edge_flag  = r_flag;
  assign edge_cnt   = r_cnt;
  assign any_flag   = r_any;

endmodule

// File: tb/tb_edge_event_detector.sv
// Testbench for edge_event_detector.
//   Three instances share clock and reset:
//     A: defaults (SYNC_STAGES=2, PULSE_LEN=1, CNT_W=8), driven from a vector table
//     B: PULSE_LEN=3, stretch / extension / reset-mid-pulse sequences
//     C: SYNC_STAGES=0, CNT_W=2, mode-switch and saturation sequences
module tb_edge_event_detector;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESETN;

  logic [3:0]  a_sig, a_clrf, a_clrc, a_pulse, a_flag;
  logic [7:0]  a_mode;
  logic [31:0] a_cnt;
  logic        a_any;

  logic [3:0]  b_sig, b_clrf, b_clrc, b_pulse, b_flag;
  logic [7:0]  b_mode;
  logic [31:0] b_cnt;
  logic        b_any;

  logic [3:0]  c_sig, c_clrf, c_clrc, c_pulse, c_flag;
  logic [7:0]  c_mode;
  logic [7:0]  c_cnt;
  logic        c_any;

  edge_event_detector u_a (
    .ACLK(ACLK), .ARESETN(ARESETN), .sig_in(a_sig), .mode(a_mode),
    .clr_flag(a_clrf), .clr_cnt(a_clrc), .edge_pulse(a_pulse),
    .edge_flag(a_flag), .edge_cnt(a_cnt), .any_flag(a_any));

  edge_event_detector #(.PULSE_LEN(3)) u_b (
    .ACLK(ACLK), .ARESETN(ARESETN), .sig_in(b_sig), .mode(b_mode),
    .clr_flag(b_clrf), .clr_cnt(b_clrc), .edge_pulse(b_pulse),
    .edge_flag(b_flag), .edge_cnt(b_cnt), .any_flag(b_any));

  edge_event_detector #(.SYNC_STAGES(0), .CNT_W(2)) u_c (
    .ACLK(ACLK), .ARESETN(ARESETN), .sig_in(c_sig), .mode(c_mode),
    .clr_flag(c_clrf), .clr_cnt(c_clrc), .edge_pulse(c_pulse),
    .edge_flag(c_flag), .edge_cnt(c_cnt), .any_flag(c_any));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  sig;
    logic [3:0]  clrf;
    logic [3:0]  clrc;
    logic [3:0]  pulse;
    logic [3:0]  flag;
    logic        any;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  pulse;
    logic [3:0]  flag;
    logic        any;
    logic [31:0] cnt;
  } exp_t;

  vec_t tbl [23];
  exp_t sbq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic vec_t v(input logic [3:0] s, input logic [3:0] cf, input logic [3:0] cc,
                             input logic [3:0] p, input logic [3:0] f, input logic a,
                             input logic [7:0] c3, input logic [7:0] c2,
                             input logic [7:0] c1, input logic [7:0] c0);
    vec_t r;
    r.sig = s; r.clrf = cf; r.clrc = cc; r.pulse = p; r.flag = f; r.any = a;
    r.cnt = {c3, c2, c1, c0};
    return r;
  endfunction

  // Mode for A: ch3=11 both, ch2=01 rise, ch1=10 fall, ch0=01 rise.
  // Each row's expectation is the output seen just after that row's edge;
  // a sig_in change shows up as a pulse two rows later.
  task automatic fill_table();
    tbl[0]  = v(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0, 0, 0);
    tbl[1]  = v(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0, 0, 0);
    tbl[2]  = v(4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1, 0, 0, 0, 1);
    tbl[3]  = v(4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 0, 0, 0, 1);
    tbl[4]  = v(4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 0, 0, 0, 1);
    tbl[5]  = v(4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 0, 0, 0, 1);
    tbl[6]  = v(4'hA, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 0, 0, 0, 1);
    tbl[7]  = v(4'hA, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 0, 0, 0, 1);
    tbl[8]  = v(4'hA, 4'h0, 4'h0, 4'h8, 4'h9, 1'b1, 1, 0, 0, 1);
    tbl[9]  = v(4'h2, 4'h0, 4'h0, 4'h0, 4'h9, 1'b1, 1, 0, 0, 1);
    tbl[10] = v(4'h2, 4'h1, 4'h0, 4'h0, 4'h8, 1'b1, 1, 0, 0, 1);
    tbl[11] = v(4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 1'b1, 2, 0, 0, 1);
    tbl[12] = v(4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 1'b1, 2, 0, 0, 1);
    tbl[13] = v(4'h0, 4'h0, 4'h0, 4'h2, 4'hA, 1'b1, 2, 0, 1, 1);
    tbl[14] = v(4'h8, 4'h0, 4'h0, 4'h0, 4'hA, 1'b1, 2, 0, 1, 1);
    tbl[15] = v(4'h8, 4'h0, 4'h0, 4'h0, 4'hA, 1'b1, 2, 0, 1, 1);
    tbl[16] = v(4'h8, 4'h8, 4'h0, 4'h8, 4'hA, 1'b1, 3, 0, 1, 1);
    tbl[17] = v(4'h8, 4'hA, 4'h1, 4'h0, 4'h0, 1'b0, 3, 0, 1, 0);
    tbl[18] = v(4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0, 0, 0, 1, 0);
    tbl[19] = v(4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0, 1, 0);
    tbl[20] = v(4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0, 1, 0);
    tbl[21] = v(4'h5, 4'h0, 4'h0, 4'hD, 4'hD, 1'b1, 1, 1, 1, 1);
    tbl[22] = v(4'h5, 4'h0, 4'h0, 4'h0, 4'hD, 1'b1, 1, 1, 1, 1);
  endtask

  // Toggle b_sig[1] every 'period' cycles, 'ntog' times, observing 'total'
  // cycles; every completed pulse must be exactly 'width' cycles long.
  task automatic b_run(input int period, input int ntog, input int total, input int width,
                       output int hi, output int rises);
    logic prev_p;
    int   run;
    prev_p = 1'b0; run = 0; hi = 0; rises = 0;
    for (int t = 0; t < total; t++) begin
      if ((t % period == 0) && (t < period * ntog)) b_sig[1] = ~b_sig[1];
      tick();
      if (b_pulse[1]) begin
        hi++; run++;
        if (!prev_p) rises++;
      end else if (prev_p) begin
        chk("B pulse width", 32'(run), 32'(width));
        run = 0;
      end
      prev_p = b_pulse[1];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hi, rises;
    logic [3:0] acc;
    logic found;
    exp_t e;

    // Reset with every input high and every mode armed for both edges.
    ARESETN = 1'b0;
    a_sig = 4'hF; b_sig = 4'hF; c_sig = 4'hF;
    a_mode = 8'hFF; b_mode = 8'hFF; c_mode = 8'hFF;
    a_clrf = '0; a_clrc = '0; b_clrf = '0; b_clrc = '0; c_clrf = '0; c_clrc = '0;
    repeat (3) tick();
    chk("A reset pulse", 32'(a_pulse), 32'd0);
    chk("A reset flag",  32'(a_flag),  32'd0);
    chk("A reset cnt",   a_cnt,        32'd0);
    chk("A reset any",   32'(a_any),   32'd0);
    chk("B reset outs",  32'({b_pulse, b_flag, b_any}), 32'd0);
    chk("C reset outs",  32'({c_pulse, c_flag, c_any}), 32'd0);

    ARESETN = 1'b1;
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      acc = acc | a_pulse | a_flag | b_pulse | b_flag | c_pulse | c_flag;
    end
    chk("release high: no pulse/flag", 32'(acc), 32'd0);
    chk("release high: A cnt", a_cnt, 32'd0);
    chk("release high: B cnt", b_cnt, 32'd0);
    chk("release high: C cnt", 32'(c_cnt), 32'd0);
    chk("release high: any", 32'({a_any, b_any, c_any}), 32'd0);

    // Fresh reset with inputs low for the functional tests.
    ARESETN = 1'b0;
    a_sig = '0; b_sig = '0; c_sig = '0;
    a_mode = 8'hD9; b_mode = 8'h0C; c_mode = 8'h00;
    repeat (2) tick();
    ARESETN = 1'b1;
    repeat (5) tick();

    fill_table();
    for (int r = 0; r < 23; r++) begin
      a_sig  = tbl[r].sig;
      a_clrf = tbl[r].clrf;
      a_clrc = tbl[r].clrc;
      e.idx = r; e.pulse = tbl[r].pulse; e.flag = tbl[r].flag;
      e.any = tbl[r].any; e.cnt = tbl[r].cnt;
      sbq.push_back(e);
      tick();
      e = sbq.pop_front();
      chk($sformatf("A row%0d pulse", e.idx), 32'(a_pulse), 32'(e.pulse));
      chk($sformatf("A row%0d flag",  e.idx), 32'(a_flag),  32'(e.flag));
      chk($sformatf("A row%0d any",   e.idx), 32'(a_any),   32'(e.any));
      chk($sformatf("A row%0d cnt",   e.idx), a_cnt,        e.cnt);
    end
    a_clrf = '0; a_clrc = '0;

    // B: slow toggles give separate 3-cycle pulses.
    b_run(6, 4, 30, 3, hi, rises);
    chk("B slow pulse count", 32'(rises), 32'd4);
    chk("B slow high cycles", 32'(hi), 32'd12);
    chk("B slow cnt ch1", 32'(b_cnt[15:8]), 32'd4);

    // B: toggles every 2 cycles keep reloading the stretch counter.
    b_run(2, 10, 30, 21, hi, rises);
    chk("B fast pulse count", 32'(rises), 32'd1);
    chk("B fast high cycles", 32'(hi), 32'd21);
    chk("B fast cnt ch1", 32'(b_cnt[15:8]), 32'd14);

    // C: mode switching on a static input never creates an event.
    acc = '0;
    c_sig = 4'h0;
    c_mode[1:0] = 2'b01; tick(); acc = acc | c_pulse | c_flag;
    c_mode[1:0] = 2'b10; tick(); acc = acc | c_pulse | c_flag;
    c_mode[1:0] = 2'b00; tick(); acc = acc | c_pulse | c_flag;
    c_sig[0] = 1'b1;     tick(); acc = acc | c_pulse | c_flag;
    tick();                      acc = acc | c_pulse | c_flag;
    c_mode[1:0] = 2'b01; tick(); acc = acc | c_pulse | c_flag;
    c_mode[1:0] = 2'b11; tick(); acc = acc | c_pulse | c_flag;
    chk("C mode switch: no pulse/flag", 32'(acc), 32'd0);
    chk("C mode switch: cnt", 32'(c_cnt), 32'd0);
    chk("C mode switch: any", 32'(c_any), 32'd0);
    c_mode[1:0] = 2'b00;

    // C: ch2 rising edges saturate a 2-bit counter; zero sync latency.
    c_mode[5:4] = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      c_sig[2] = 1'b1; tick();
      chk($sformatf("C edge%0d pulse", k), 32'(c_pulse[2]), 32'd1);
      chk($sformatf("C edge%0d cnt", k), 32'(c_cnt[5:4]), 32'((k > 3) ? 3 : k));
      c_sig[2] = 1'b0; tick();
    end
    c_sig[2] = 1'b1; c_clrc[2] = 1'b1; tick();
    c_clrc[2] = 1'b0;
    chk("C clr_cnt with edge", 32'(c_cnt[5:4]), 32'd1);
    c_clrc[2] = 1'b1; tick();
    c_clrc[2] = 1'b0;
    chk("C clr_cnt alone", 32'(c_cnt[5:4]), 32'd0);
    chk("C flag ch2 kept", 32'(c_flag), 32'h4);

    // B: reset asserted while a stretched pulse is active.
    b_sig[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      found = b_pulse[1];
    end
    chk("B pulse before reset", 32'(found), 32'd1);
    ARESETN = 1'b0;
    tick();
    chk("B reset mid-pulse", 32'(b_pulse), 32'd0);
    chk("B reset flag", 32'(b_flag), 32'd0);
    chk("B reset cnt", b_cnt, 32'd0);
    ARESETN = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_event_detector.md
EDGE_EVENT_DETECTOR -- requirements
Module: edge_event_detector

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels, legal 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel ahead of detection, legal 0..3.
REQ-003 Parameter PULSE_LEN, default 1: edge_pulse width in cycles, legal 1..15.
REQ-004 Parameter CNT_W, default 8: per-channel event counter width, legal 1..16.
REQ-005 ACLK  input  1  sole clock; all logic on rising edge.
REQ-006 ARESETN  input  1  reset, synchronous, active-low.
REQ-007 sig_in  input  NUM_CH  monitored signals, possibly asynchronous to ACLK.
REQ-008 mode  input  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 clr_flag  input  NUM_CH  per-channel sticky-flag clear, one-cycle strobe.
REQ-010 clr_cnt  input  NUM_CH  per-channel counter clear, one-cycle strobe.
REQ-011 edge_pulse  output  NUM_CH  per-channel stretched event pulse, registered.
REQ-012 edge_flag  output  NUM_CH  per-channel sticky event flag, registered.
REQ-013 edge_cnt  output  NUM_CH*CNT_W  per-channel saturating event count, channel i at [CNT_W*i +: CNT_W].
REQ-014 any_flag  output  1  OR of all edge_flag bits, registered alongside edge_flag.

Function
REQ-015 Each channel SHALL pass sig_in[i] through SYNC_STAGES flops (none when 0), then a "prev" flop holding the prior synchronised value.
REQ-016 Detect (combinational): rise = sync & ~prev; fall = ~sync & prev; det = (mode[0] & rise) | (mode[1] & fall), gated by the arm condition (REQ-024).
REQ-017 Latency: for a sig_in change first sampled at ACLK edge N, edge_pulse SHALL go high after edge N+SYNC_STAGES; SYNC_STAGES=0 gives high after edge N.
REQ-018 Stretch: det SHALL load a per-channel down-counter so edge_pulse stays high exactly PULSE_LEN cycles; det during an active pulse SHALL reload it (extends, no gap).
REQ-019 edge_flag[i] SHALL set on det and clear on clr_flag[i]; simultaneous det and clr_flag leave the flag set.
REQ-020 edge_cnt[i] SHALL increment by 1 per det cycle and saturate at 2^CNT_W-1 (no wrap).
REQ-021 clr_cnt[i] SHALL load 0; clr_cnt with simultaneous det SHALL load 1.
REQ-022 The prev flop SHALL update every cycle regardless of mode; mode changes SHALL never produce a spurious event, and mode=00 SHALL suppress det, leaving flag/count unchanged.
REQ-023 Channels SHALL be fully independent; events on several channels in the same cycle are all recorded.

Reset
REQ-024 ARESETN=0 sampled at an edge SHALL clear synchronisers, prev, stretch counters, edge_pulse, edge_flag, edge_cnt, any_flag to 0; a module-wide arm counter SHALL mask det for the first SYNC_STAGES+1 edges after ARESETN returns high, so a level high at release is not an event.
REQ-025 Reset asserted mid-pulse SHALL drop edge_pulse at the next edge; no event straddling reset is recorded.

Verification
REQ-026 Defaults, mode ch0=01, sig_in[0] 0->1 held: edge_pulse[0] high exactly 1 cycle, 2 edges after first sampling edge; edge_flag[0]=1, edge_cnt ch0=1; 1->0 gives no event.
REQ-027 mode ch1=11, PULSE_LEN=3, sig_in[1] toggled every 6 cycles x4: 4 pulses of 3 cycles each, edge_cnt ch1=4; toggle every 2 cycles: pulse stays continuously high.
REQ-028 CNT_W=2, 5 rising edges on ch2: edge_cnt ch2 stays 3; clr_cnt[2] coincident with a 6th edge: edge_cnt ch2=1.
REQ-029 edge_flag[3]=1, clr_flag[3] pulsed coincident with a new detected edge: flag stays 1, any_flag=1; clr_flag alone: flag 0, any_flag 0 when no other flag set.
REQ-030 sig_in all 1 during reset, ARESETN released: no pulses, flags or counts for any channel; ARESETN dropped mid-stretch: edge_pulse 0 at next edge.
REQ-031 SYNC_STAGES=0, rise mode, mode switched 01->10->00 while sig_in static: zero events; then 0->1 in mode 00: none, flag/count unchanged.
